// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants.
package cpu_pkg;

    localparam int unsigned DATA_W = 4;

endpackage

// File: rtl/four_bit_register_if.sv
// Load/clear/data bundle for the datapath storage register.
interface four_bit_register_if
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W
);

    logic [WIDTH-1:0] in;
    logic             enable;
    logic             clear;
    logic [WIDTH-1:0] Q;

    modport master (
        output in,
        output enable,
        output clear,
        input  Q
    );

    modport slave (
        input  in,
        input  enable,
        input  clear,
        output Q
    );

endinterface

// File: rtl/register_bit_cell.sv
// One storage bit: async active-low reset, synchronous clear over load enable.
module register_bit_cell #(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    input  logic en,
    input  logic clr,
    output logic q
);

    logic q_q;
    logic q_d;

    // clear has priority over a load
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = RESET_BIT;
        end else if (en) begin
            q_d = d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= RESET_BIT;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/four_bit_register.sv
// WIDTH-bit datapath storage register built from per-bit cells.
module four_bit_register
    import cpu_pkg::*;
#(
    parameter int unsigned      WIDTH       = DATA_W,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic CLK,
    input  logic RST_N,
    four_bit_register_if.slave bus
);

    logic [WIDTH-1:0] q_vec;

    // each slice takes its own bit of RESET_VALUE
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
        register_bit_cell #(
            .RESET_BIT (RESET_VALUE[i])
        ) u_cell (
            .clk   (CLK),
            .rst_n (RST_N),
            .d     (bus.in[i]),
            .en    (bus.enable),
            .clr   (bus.clear),
            .q     (q_vec[i])
        );
    end

    assign bus.Q = q_vec;

endmodule

// File: tb/tb_four_bit_register.sv
// Bench for four_bit_register: directed scenarios plus random traffic on two widths.
module tb_four_bit_register;

    localparam int unsigned     W4  = 4;
    localparam int unsigned     W8  = 8;
    localparam logic [W4-1:0]   RV4 = 4'h0;
    localparam logic [W8-1:0]   RV8 = 8'hA5;

    logic CLK   = 1'b0;
    logic RST_N = 1'b1;

    four_bit_register_if #(.WIDTH(W4)) bus4 ();
    four_bit_register_if #(.WIDTH(W8)) bus8 ();

    four_bit_register #(.WIDTH(W4), .RESET_VALUE(RV4)) dut4 (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus4)
    );

    four_bit_register #(.WIDTH(W8), .RESET_VALUE(RV8)) dut8 (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus8)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [W4-1:0] exp4;
    logic [W8-1:0] exp8;

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic check_both(input string tag);
        check({tag, "/w4"}, 64'(bus4.Q), 64'(exp4));
        check({tag, "/w8"}, 64'(bus8.Q), 64'(exp8));
    endtask

    task automatic drive(input logic [W8-1:0] d, input logic en, input logic clr);
        bus4.in     = d[W4-1:0];
        bus4.enable = en;
        bus4.clear  = clr;
        bus8.in     = d;
        bus8.enable = en;
        bus8.clear  = clr;
    endtask

    // drive at the falling edge, confirm Q has not moved yet, then confirm the edge result
    task automatic step(input string tag, input logic [W8-1:0] d, input logic en, input logic clr);
        @(negedge CLK);
        drive(d, en, clr);
        #1;
        check_both({tag, "/pre"});
        if (clr) begin
            exp4 = RV4;
            exp8 = RV8;
        end else if (en) begin
            exp4 = d[W4-1:0];
            exp8 = d;
        end
        @(posedge CLK);
        #1;
        check_both({tag, "/post"});
    endtask

    // short reset pulse between edges; called just after a rising edge
    task automatic mid_reset(input string tag);
        RST_N = 1'b0;
        exp4  = RV4;
        exp8  = RV8;
        #1;
        check_both({tag, "/low"});
        #1;
        RST_N = 1'b1;
        #1;
        check_both({tag, "/rel"});
    endtask

    initial begin
        drive(8'h00, 1'b0, 1'b0);
        exp4 = RV4;
        exp8 = RV8;

        // async reset before any clock edge, held after release
        #2;
        RST_N = 1'b0;
        #1;
        check_both("rst_async");
        #5;
        RST_N = 1'b1;
        #1;
        check_both("rst_release");

        step("load_1100", 8'h3C, 1'b1, 1'b0);
        step("load_0011", 8'hC3, 1'b1, 1'b0);
        step("clr_over_en", 8'hC3, 1'b1, 1'b1);
        step("clr_release", 8'hC3, 1'b1, 1'b0);
        step("hold_a", 8'h5A, 1'b0, 1'b0);
        step("hold_b", 8'h5A, 1'b0, 1'b0);
        step("hold_c", 8'h5A, 1'b0, 1'b0);
        step("reen_1010", 8'h5A, 1'b1, 1'b0);
        step("reen_0101", 8'hA5, 1'b1, 1'b0);
        step("clr_no_en", 8'hFF, 1'b0, 1'b1);

        // reset during a pending load, then the load lands on the next edge
        step("pre_rst_load", 8'hFF, 1'b1, 1'b0);
        step("pre_rst_load2", 8'h0F, 1'b1, 1'b0);
        drive(8'hFF, 1'b1, 1'b0);
        mid_reset("rst_mid_load");
        @(posedge CLK);
        exp4 = 4'hF;
        exp8 = 8'hFF;
        #1;
        check_both("load_after_rst");

        // reset held low across a rising edge with a load requested
        RST_N = 1'b0;
        exp4  = RV4;
        exp8  = RV8;
        #1;
        check_both("rst_hold_low");
        @(posedge CLK);
        #1;
        check_both("rst_hold_edge");
        RST_N = 1'b1;
        #1;
        check_both("rst_hold_rel");

        // random traffic with occasional reset pulses
        for (int i = 0; i < 300; i++) begin
            logic [W8-1:0] d;
            logic          en;
            logic          clr;
            d   = W8'($urandom);
            en  = 1'($urandom_range(0, 1));
            clr = ($urandom_range(0, 3) == 0);
            step("rand", d, en, clr);
            if ($urandom_range(0, 15) == 0) begin
                mid_reset("rand_rst");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
